// File: rtl/morra_pkg.sv
// Shared definitions for the Morra Cinese scoreboard.
// Contents:
//   - MANCHE/PARTITA result codes.
//   - Scoreboard FSM state type.
//   - Width of the per-game round counters.
//   - Saturating increment helper used by every counter.
package morra_pkg;

    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_P1   = 2'b01;
    localparam logic [1:0] M_P2   = 2'b10;
    localparam logic [1:0] M_PARI = 2'b11;

    localparam int unsigned W_CNT = 5;

    typedef enum logic [1:0] {
        ATTESA,
        GIOCO,
        CHIUSA
    } stato_t;

    // Callers widen the operand to 32 bits and cast the result back to the counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/morra_storico.sv
// History ring buffer of 2-bit round codes, oldest entry first.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clr_i               empty the buffer (contents are not scrubbed)
//   push_i, push_data_i append an entry; when full, the oldest entry is overwritten
//   pop_i               remove the oldest entry into rd_data_o (ignored when empty)
//   rd_data_o           last popped entry, held until the next successful pop
//   rd_valid_o          rd_data_o was updated at the last clock edge
//   vuoto_o, pieno_o    buffer empty / full
module morra_storico #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [1:0] push_data_i,
    input  logic       pop_i,
    output logic [1:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       vuoto_o,
    output logic       pieno_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_PIENO = CW'(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          we;
    logic          pop_ok;
    logic          full;

    assign pop_ok = pop_i && (cnt_q != '0);
    assign full   = (cnt_q == CNT_PIENO);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop_ok) begin
                // Read uses the pre-edge contents, so a same-cycle push into this slot is safe.
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end
            if (push_i) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (!pop_ok) begin
                    if (full) begin
                        // Overwrite: the oldest entry is dropped, so the read side moves too.
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end else if (pop_ok) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign vuoto_o    = (cnt_q == '0);
    assign pieno_o    = full;

endmodule

// File: rtl/morra_tabellone.sv
// Scoreboard for the Morra Cinese game FSM.
// Samples MANCHE/PARTITA each cycle. Keeps:
//   - per-game round tallies
//   - lifetime game totals
//   - the result of the last finished game
//   - a history of recent rounds
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   INIZIO         start a new game (clears per-game state, keeps lifetime totals)
//   MANCHE         round code (00 none, 01 P1, 10 P2, 11 draw)
//   PARTITA        game-end code, same encoding, 00 = game continues
//   RD_EN          pop the oldest history entry
//   VITTORIE_1/2   rounds won by P1/P2 in the current game (saturating)
//   PAREGGI        drawn rounds in the current game
//   N_MANCHE       valid rounds in the current game
//   VANTAGGIO      signed VITTORIE_1 - VITTORIE_2
//   PARTITE_*      lifetime games won by P1, P2 or drawn (saturating)
//   RISULTATO      PARTITA code of the last finished game
//   FINE           one-cycle pulse when a game ends
//   ERRORE         sticky flag: game end reported without a valid round
//   RD_DATA        last popped history entry
//   RD_VALID       RD_DATA updated this cycle
//   VUOTO, PIENO   history empty / full
module morra_tabellone
    import morra_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned W_PART = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              INIZIO,
    input  logic [1:0]        MANCHE,
    input  logic [1:0]        PARTITA,
    input  logic              RD_EN,
    output logic [4:0]        VITTORIE_1,
    output logic [4:0]        VITTORIE_2,
    output logic [4:0]        PAREGGI,
    output logic [4:0]        N_MANCHE,
    output logic [5:0]        VANTAGGIO,
    output logic [W_PART-1:0] PARTITE_1,
    output logic [W_PART-1:0] PARTITE_2,
    output logic [W_PART-1:0] PARTITE_PARI,
    output logic [1:0]        RISULTATO,
    output logic              FINE,
    output logic              ERRORE,
    output logic [1:0]        RD_DATA,
    output logic              RD_VALID,
    output logic              VUOTO,
    output logic              PIENO
);

    localparam logic [31:0] CNT_MAX  = (32'd1 << W_CNT) - 32'd1;
    localparam logic [31:0] PART_MAX = (32'd1 << W_PART) - 32'd1;

    stato_t            stato_q, stato_d;
    logic [4:0]        v1_q, v1_d;
    logic [4:0]        v2_q, v2_d;
    logic [4:0]        pari_q, pari_d;
    logic [4:0]        n_manche_q, n_manche_d;
    logic [5:0]        vant_q, vant_d;
    logic [W_PART-1:0] partite_1_q, partite_1_d;
    logic [W_PART-1:0] partite_2_q, partite_2_d;
    logic [W_PART-1:0] partite_pari_q, partite_pari_d;
    logic [1:0]        risultato_q, risultato_d;
    logic              fine_q, fine_d;
    logic              errore_q, errore_d;
    logic              push;
    logic              pop;
    logic              clr;

    always_comb begin
        stato_d        = stato_q;
        v1_d           = v1_q;
        v2_d           = v2_q;
        pari_d         = pari_q;
        n_manche_d     = n_manche_q;
        partite_1_d    = partite_1_q;
        partite_2_d    = partite_2_q;
        partite_pari_d = partite_pari_q;
        risultato_d    = risultato_q;
        fine_d         = 1'b0;
        errore_d       = errore_q;
        push           = 1'b0;
        clr            = 1'b0;

        if (INIZIO) begin
            v1_d        = '0;
            v2_d        = '0;
            pari_d      = '0;
            n_manche_d  = '0;
            risultato_d = M_NONE;
            errore_d    = 1'b0;
            clr         = 1'b1;
            stato_d     = GIOCO;
        end else begin
            case (stato_q)
                GIOCO: begin
                    if (MANCHE != M_NONE) begin
                        push       = 1'b1;
                        n_manche_d = 5'(sat_inc(32'(n_manche_q), CNT_MAX));
                        case (MANCHE)
                            M_P1:    v1_d   = 5'(sat_inc(32'(v1_q), CNT_MAX));
                            M_P2:    v2_d   = 5'(sat_inc(32'(v2_q), CNT_MAX));
                            default: pari_d = 5'(sat_inc(32'(pari_q), CNT_MAX));
                        endcase
                        if (PARTITA != M_NONE) begin
                            case (PARTITA)
                                M_P1:    partite_1_d = W_PART'(sat_inc(32'(partite_1_q), PART_MAX));
                                M_P2:    partite_2_d = W_PART'(sat_inc(32'(partite_2_q), PART_MAX));
                                default: partite_pari_d =
                                             W_PART'(sat_inc(32'(partite_pari_q), PART_MAX));
                            endcase
                            risultato_d = PARTITA;
                            fine_d      = 1'b1;
                            stato_d     = CHIUSA;
                        end
                    end else if (PARTITA != M_NONE) begin
                        // A game cannot end without its deciding round: flag it and carry on.
                        errore_d = 1'b1;
                    end
                end
                default: ; // ATTESA and CHIUSA ignore the game FSM
            endcase
        end

        // Both operands are already saturated, so the difference always fits in 6 bits.
        vant_d = {1'b0, v1_d} - {1'b0, v2_d};
    end

    assign pop = RD_EN && !INIZIO;

    always_ff @(posedge clk) begin
        if (rst) begin
            stato_q        <= ATTESA;
            v1_q           <= '0;
            v2_q           <= '0;
            pari_q         <= '0;
            n_manche_q     <= '0;
            vant_q         <= '0;
            partite_1_q    <= '0;
            partite_2_q    <= '0;
            partite_pari_q <= '0;
            risultato_q    <= M_NONE;
            fine_q         <= 1'b0;
            errore_q       <= 1'b0;
        end else begin
            stato_q        <= stato_d;
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            pari_q         <= pari_d;
            n_manche_q     <= n_manche_d;
            vant_q         <= vant_d;
            partite_1_q    <= partite_1_d;
            partite_2_q    <= partite_2_d;
            partite_pari_q <= partite_pari_d;
            risultato_q    <= risultato_d;
            fine_q         <= fine_d;
            errore_q       <= errore_d;
        end
    end

    morra_storico #(
        .DEPTH(DEPTH)
    ) u_storico (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .push_i     (push),
        .push_data_i(MANCHE),
        .pop_i      (pop),
        .rd_data_o  (RD_DATA),
        .rd_valid_o (RD_VALID),
        .vuoto_o    (VUOTO),
        .pieno_o    (PIENO)
    );

    assign VITTORIE_1   = v1_q;
    assign VITTORIE_2   = v2_q;
    assign PAREGGI      = pari_q;
    assign N_MANCHE     = n_manche_q;
    assign VANTAGGIO    = vant_q;
    assign PARTITE_1    = partite_1_q;
    assign PARTITE_2    = partite_2_q;
    assign PARTITE_PARI = partite_pari_q;
    assign RISULTATO    = risultato_q;
    assign FINE         = fine_q;
    assign ERRORE       = errore_q;

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone.
// History reads are checked through a scoreboard:
//   - expected entries are queued when the pop is driven;
//   - a negedge monitor compares them when RD_VALID appears.
module tb_morra_tabellone;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned W_PART = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              INIZIO;
    logic [1:0]        MANCHE;
    logic [1:0]        PARTITA;
    logic              RD_EN;
    logic [4:0]        VITTORIE_1;
    logic [4:0]        VITTORIE_2;
    logic [4:0]        PAREGGI;
    logic [4:0]        N_MANCHE;
    logic [5:0]        VANTAGGIO;
    logic [W_PART-1:0] PARTITE_1;
    logic [W_PART-1:0] PARTITE_2;
    logic [W_PART-1:0] PARTITE_PARI;
    logic [1:0]        RISULTATO;
    logic              FINE;
    logic              ERRORE;
    logic [1:0]        RD_DATA;
    logic              RD_VALID;
    logic              VUOTO;
    logic              PIENO;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] hist_m[$];
    logic [1:0] sb_q[$];
    logic [1:0] sb_exp;
    bit         in_game = 1'b0;

    morra_tabellone #(
        .DEPTH (DEPTH),
        .W_PART(W_PART)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .INIZIO      (INIZIO),
        .MANCHE      (MANCHE),
        .PARTITA     (PARTITA),
        .RD_EN       (RD_EN),
        .VITTORIE_1  (VITTORIE_1),
        .VITTORIE_2  (VITTORIE_2),
        .PAREGGI     (PAREGGI),
        .N_MANCHE    (N_MANCHE),
        .VANTAGGIO   (VANTAGGIO),
        .PARTITE_1   (PARTITE_1),
        .PARTITE_2   (PARTITE_2),
        .PARTITE_PARI(PARTITE_PARI),
        .RISULTATO   (RISULTATO),
        .FINE        (FINE),
        .ERRORE      (ERRORE),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .VUOTO       (VUOTO),
        .PIENO       (PIENO)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every RD_VALID must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && RD_VALID) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: RD_VALID=1 RD_DATA=%b, required no valid read", RD_DATA);
            end else begin
                sb_exp = sb_q.pop_front();
                if (RD_DATA !== sb_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got %b want %b", RD_DATA, sb_exp);
                end
            end
        end
    end

    // Drive one cycle of stimulus and update the reference history model.
    task automatic cycle(input logic ini, input logic [1:0] m, input logic [1:0] p,
                         input logic rd);
        INIZIO  = ini;
        MANCHE  = m;
        PARTITA = p;
        RD_EN   = rd;
        if (ini) begin
            hist_m.delete();
            in_game = 1'b1;
        end else begin
            if (rd && hist_m.size() > 0) sb_q.push_back(hist_m.pop_front());
            if (in_game && m != 2'b00) begin
                if (hist_m.size() == DEPTH) hist_m.delete(0);
                hist_m.push_back(m);
                if (p != 2'b00) in_game = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        INIZIO  = 1'b0;
        MANCHE  = 2'b00;
        PARTITA = 2'b00;
        RD_EN   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        INIZIO = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00; RD_EN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hist_m.delete();
        sb_q.delete();
        in_game = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (VITTORIE_1 !== 5'd0 || VITTORIE_2 !== 5'd0 || PAREGGI !== 5'd0 || N_MANCHE !== 5'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want 0/0/0/0", VITTORIE_1, VITTORIE_2, PAREGGI, N_MANCHE); end
        n_checks++; if (VANTAGGIO !== 6'd0 || RISULTATO !== 2'b00 || RD_DATA !== 2'b00) begin
            n_fail++; $display("FAIL reset_misc: got vant=%0d ris=%b rd=%b want 0/00/00", VANTAGGIO, RISULTATO, RD_DATA); end
        n_checks++; if (PARTITE_1 !== '0 || PARTITE_2 !== '0 || PARTITE_PARI !== '0) begin
            n_fail++; $display("FAIL reset_partite: got %0d/%0d/%0d want 0/0/0", PARTITE_1, PARTITE_2, PARTITE_PARI); end
        n_checks++; if ({FINE, ERRORE, RD_VALID, PIENO, VUOTO} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00001", {FINE, ERRORE, RD_VALID, PIENO, VUOTO}); end
        // ATTESA must ignore rounds.
        repeat (3) cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (VITTORIE_1 !== 5'd0 || N_MANCHE !== 5'd0 || VUOTO !== 1'b1) begin
            n_fail++; $display("FAIL attesa_ignore: got v1=%0d n=%0d vuoto=%b want 0/0/1", VITTORIE_1, N_MANCHE, VUOTO); end
    endtask

    task automatic test_game_basic();
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        cycle(1'b0, 2'b10, 2'b00, 1'b0);
        cycle(1'b0, 2'b11, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (VITTORIE_1 !== 5'd2 || VITTORIE_2 !== 5'd1 || PAREGGI !== 5'd1 || N_MANCHE !== 5'd4) begin
            n_fail++; $display("FAIL basic_counters: got %0d/%0d/%0d/%0d want 2/1/1/4", VITTORIE_1, VITTORIE_2, PAREGGI, N_MANCHE); end
        n_checks++; if (VANTAGGIO !== 6'd1) begin
            n_fail++; $display("FAIL basic_vantaggio: got %0d want 1", $signed(VANTAGGIO)); end
        n_checks++; if (VUOTO !== 1'b0 || PIENO !== 1'b0) begin
            n_fail++; $display("FAIL basic_occupancy: got vuoto=%b pieno=%b want 0/0", VUOTO, PIENO); end
        repeat (4) cycle(1'b0, 2'b00, 2'b00, 1'b1);
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        n_checks++; if (VUOTO !== 1'b1 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL basic_drain: got vuoto=%b pending=%0d want 1/0", VUOTO, sb_q.size()); end
    endtask

    task automatic test_game_end();
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b10, 2'b10, 1'b0);
        n_checks++; if (PARTITE_2 !== 8'd1 || RISULTATO !== 2'b10 || FINE !== 1'b1 || VITTORIE_2 !== 5'd1) begin
            n_fail++; $display("FAIL end_latch: got p2=%0d ris=%b fine=%b v2=%0d want 1/10/1/1", PARTITE_2, RISULTATO, FINE, VITTORIE_2); end
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (FINE !== 1'b0 || VITTORIE_1 !== 5'd0 || N_MANCHE !== 5'd1 || RISULTATO !== 2'b10) begin
            n_fail++; $display("FAIL end_hold: got fine=%b v1=%0d n=%0d ris=%b want 0/0/1/10", FINE, VITTORIE_1, N_MANCHE, RISULTATO); end
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        n_checks++; if (VITTORIE_2 !== 5'd0 || N_MANCHE !== 5'd0 || RISULTATO !== 2'b00 || PARTITE_2 !== 8'd1 || PARTITE_1 !== 8'd0) begin
            n_fail++; $display("FAIL end_restart: got v2=%0d n=%0d ris=%b p2=%0d p1=%0d want 0/0/00/1/0", VITTORIE_2, N_MANCHE, RISULTATO, PARTITE_2, PARTITE_1); end
    endtask

    task automatic test_full();
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        repeat (2) cycle(1'b0, 2'b01, 2'b00, 1'b0);
        repeat (8) cycle(1'b0, 2'b10, 2'b00, 1'b0);
        n_checks++; if (PIENO !== 1'b1 || N_MANCHE !== 5'd10 || VANTAGGIO !== 6'b111010) begin
            n_fail++; $display("FAIL full_state: got pieno=%b n=%0d vant=%0d want 1/10/-6", PIENO, N_MANCHE, $signed(VANTAGGIO)); end
        repeat (8) cycle(1'b0, 2'b00, 2'b00, 1'b1);
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        n_checks++; if (VUOTO !== 1'b1 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL full_drain: got vuoto=%b pending=%0d want 1/0", VUOTO, sb_q.size()); end
        cycle(1'b0, 2'b00, 2'b00, 1'b1);
        n_checks++; if (RD_VALID !== 1'b0 || RD_DATA !== 2'b10) begin
            n_fail++; $display("FAIL empty_pop: got valid=%b data=%b want 0/10", RD_VALID, RD_DATA); end
    endtask

    task automatic test_errore();
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b01, 1'b0);
        n_checks++; if (ERRORE !== 1'b1 || N_MANCHE !== 5'd1 || PARTITE_1 !== 8'd0 || FINE !== 1'b0) begin
            n_fail++; $display("FAIL err_set: got err=%b n=%0d p1=%0d fine=%b want 1/1/0/0", ERRORE, N_MANCHE, PARTITE_1, FINE); end
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (ERRORE !== 1'b1 || N_MANCHE !== 5'd2 || VITTORIE_1 !== 5'd2) begin
            n_fail++; $display("FAIL err_sticky: got err=%b n=%0d v1=%0d want 1/2/2", ERRORE, N_MANCHE, VITTORIE_1); end
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        n_checks++; if (ERRORE !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b want 0", ERRORE); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] pat [8];
        pat = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, pat[i], 2'b00, 1'b0);
        cycle(1'b0, 2'b11, 2'b00, 1'b1);
        n_checks++; if (PIENO !== 1'b1 || RD_VALID !== 1'b1 || N_MANCHE !== 5'd9 || PAREGGI !== 5'd3) begin
            n_fail++; $display("FAIL b2b_state: got pieno=%b valid=%b n=%0d pari=%0d want 1/1/9/3", PIENO, RD_VALID, N_MANCHE, PAREGGI); end
        // Draining confirms the same-cycle push did not overwrite anything.
        repeat (8) cycle(1'b0, 2'b00, 2'b00, 1'b1);
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        n_checks++; if (VUOTO !== 1'b1 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got vuoto=%b pending=%0d want 1/0", VUOTO, sb_q.size()); end
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        repeat (40) cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (VITTORIE_1 !== 5'd31 || N_MANCHE !== 5'd31 || VANTAGGIO !== 6'd31 || PIENO !== 1'b1) begin
            n_fail++; $display("FAIL saturation: got v1=%0d n=%0d vant=%0d pieno=%b want 31/31/31/1", VITTORIE_1, N_MANCHE, VANTAGGIO, PIENO); end
    endtask

    task automatic test_rst_midgame();
        cycle(1'b1, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        do_reset();
        cycle(1'b0, 2'b01, 2'b00, 1'b0);
        n_checks++; if (PARTITE_2 !== 8'd0 || VITTORIE_1 !== 5'd0 || N_MANCHE !== 5'd0 || VUOTO !== 1'b1) begin
            n_fail++; $display("FAIL rst_midgame: got p2=%0d v1=%0d n=%0d vuoto=%b want 0/0/0/1", PARTITE_2, VITTORIE_1, N_MANCHE, VUOTO); end
    endtask

    initial begin
        rst = 1'b1;
        INIZIO = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00; RD_EN = 1'b0;
        test_reset();
        test_game_basic();
        test_game_end();
        test_full();
        test_errore();
        test_back_to_back();
        test_rst_midgame();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
- Scoreboard stage directly downstream of the Morra Cinese game FSM.
- Samples the FSM's per-cycle MANCHE and PARTITA codes.
- Keeps per-game round tallies and lifetime game totals.
- Latches the final game result and stores a readable history of the most recent manche in a ring buffer, for display/debug logic.

Parameters:
- DEPTH, 8, history ring-buffer entries (power of 2, 2..32)
- W_PART, 8, width of lifetime game counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- INIZIO  in  1  start of new game (same signal fed to the game FSM)
- MANCHE  in  2  round code: 00 none/invalid, 01 P1, 10 P2, 11 draw
- PARTITA  in  2  game-end code, same encoding; 00 = game continues
- RD_EN  in  1  pop oldest history entry
- VITTORIE_1  out  5  rounds won by P1, current game
- VITTORIE_2  out  5  rounds won by P2, current game
- PAREGGI  out  5  drawn rounds, current game
- N_MANCHE  out  5  valid rounds played, current game
- VANTAGGIO  out  6  signed VITTORIE_1 - VITTORIE_2
- PARTITE_1  out  W_PART  games won by P1 since rst
- PARTITE_2  out  W_PART  games won by P2 since rst
- PARTITE_PARI  out  W_PART  drawn games since rst
- RISULTATO  out  2  latched PARTITA of last finished game
- FINE  out  1  one-cycle pulse when a game ends
- ERRORE  out  1  sticky protocol-error flag
- RD_DATA  out  2  popped history entry
- RD_VALID  out  1  RD_DATA valid this cycle
- VUOTO  out  1  history empty
- PIENO  out  1  history full

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - All counters, VANTAGGIO, RISULTATO, RD_DATA: 0.
  - FINE, ERRORE, RD_VALID, PIENO: 0.
  - VUOTO: 1.
  - State: ATTESA.
- All outputs are registered and reflect inputs sampled at the previous clk edge (latency 1).
- FSM states:
  - ATTESA: MANCHE and PARTITA ignored.
  - GIOCO: live game.
  - CHIUSA: game finished, result held.
- INIZIO=1 in any state (rst has priority):
  - Clears the per-game counters, VANTAGGIO and the history buffer.
  - Clears RISULTATO and ERRORE.
  - Next state is GIOCO.
  - MANCHE/PARTITA and RD_EN in that cycle are ignored; lifetime PARTITE_* are kept.
- GIOCO, per cycle:
  - MANCHE 01/10/11: increment VITTORIE_1 / VITTORIE_2 / PAREGGI respectively, increment N_MANCHE, push the code into history.
  - MANCHE 00: no change.
- GIOCO with PARTITA != 00 and MANCHE != 00 in the same cycle:
  - The round is counted as above.
  - The matching PARTITE_1/PARTITE_2/PARTITE_PARI is incremented.
  - RISULTATO <= PARTITA, FINE pulses high for exactly one cycle, next state is CHIUSA.
- GIOCO with PARTITA != 00 but MANCHE == 00: ERRORE <= 1; the event is ignored and the state stays GIOCO.
- CHIUSA:
  - MANCHE/PARTITA ignored.
  - RISULTATO and the counters hold.
  - History remains readable.
  - Leaves only on INIZIO or rst.
- Saturation:
  - Per-game 5-bit counters saturate at 31.
  - PARTITE_* saturate at 2^W_PART-1.
  - VANTAGGIO is computed from the saturated values, 6-bit two's complement.
- History ring buffer: keeps the last DEPTH valid rounds, oldest first.
  - Push when full: overwrite the oldest entry; PIENO stays 1.
  - RD_EN with VUOTO=0: RD_DATA <= oldest entry, RD_VALID=1 next cycle, entry removed.
  - RD_EN with VUOTO=1: RD_VALID=0 and RD_DATA holds its value.
  - Push and pop in the same cycle: the pop returns the oldest entry before the push. When full, the push goes into the freed slot, nothing is overwritten, and occupancy is unchanged.
- rst mid-game clears everything, including the lifetime totals; INIZIO does not clear the lifetime totals.

Decomposition:
- Package morra_pkg holds:
  - Codes M_NONE=2'b00, M_P1=2'b01, M_P2=2'b10, M_PARI=2'b11.
  - State enum {ATTESA, GIOCO, CHIUSA}.
  - Saturating-increment function.
- Sub-module morra_storico: parameterised 2-bit ring buffer with push, pop, clear, overwrite-on-full, RD_DATA/RD_VALID, VUOTO/PIENO.
- Top level holds the FSM, the counters and the saturation logic.

Test Plan:
- rst, then MANCHE=01 for 3 cycles without INIZIO -> all counters 0, VUOTO=1 (ATTESA ignores input).
- INIZIO, then MANCHE 01,10,11,00,01 -> VITTORIE_1=2, VITTORIE_2=1, PAREGGI=1, N_MANCHE=4, VANTAGGIO=+1; four RD_EN pops -> RD_DATA 01,10,11,01, then VUOTO=1.
- In GIOCO drive MANCHE=10 with PARTITA=10 -> PARTITE_2=1, RISULTATO=10, FINE high for one cycle; further MANCHE=01 ignored; next INIZIO clears the round counters, PARTITE_2 stays 1.
- With DEPTH=8, push 10 rounds (01 x2, then 10 x8) -> PIENO=1; eight pops all return 10; first RD_EN after that gives RD_VALID=0.
- PARTITA=01 with MANCHE=00 in GIOCO -> ERRORE=1 (sticky), no counter change; INIZIO clears ERRORE.
- Push and pop in the same cycle when full -> popped entry is the oldest, occupancy stays DEPTH; 40 consecutive MANCHE=01 -> VITTORIE_1 saturates at 31, VANTAGGIO=+31.
